// File: rtl/result_bcd_display_pkg.sv
// Shared constants for result_bcd_display: active-low segment codes, FSM states
// and the per-nibble add-3 step of the double-dabble conversion.
package result_bcd_display_pkg;

    localparam logic [6:0] SEG_0     = 7'b1000000;
    localparam logic [6:0] SEG_1     = 7'b1111001;
    localparam logic [6:0] SEG_2     = 7'b0100100;
    localparam logic [6:0] SEG_3     = 7'b0110000;
    localparam logic [6:0] SEG_4     = 7'b0011001;
    localparam logic [6:0] SEG_5     = 7'b0010010;
    localparam logic [6:0] SEG_6     = 7'b0000010;
    localparam logic [6:0] SEG_7     = 7'b1111000;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0010000;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [6:0] SEG_MINUS = 7'b0111111;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_CONV = 1'b1
    } state_t;

    function automatic logic [3:0] add3(input logic [3:0] nib);
        return (nib >= 4'd5) ? nib + 4'd3 : nib;
    endfunction

endpackage

// File: rtl/result_bcd_display_seg7_digit.sv
// seg7_digit: one BCD nibble to active-low seven-segment code, with blank enable.
// Nibbles above 9 decode to blank.
module seg7_digit
    import result_bcd_display_pkg::*;
(
    input  logic [3:0] i_digit,
    input  logic       i_blank,
    output logic [6:0] o_seg
);

    always_comb begin
        o_seg = SEG_BLANK;
        if (!i_blank) begin
            case (i_digit)
                4'd0:    o_seg = SEG_0;
                4'd1:    o_seg = SEG_1;
                4'd2:    o_seg = SEG_2;
                4'd3:    o_seg = SEG_3;
                4'd4:    o_seg = SEG_4;
                4'd5:    o_seg = SEG_5;
                4'd6:    o_seg = SEG_6;
                4'd7:    o_seg = SEG_7;
                4'd8:    o_seg = SEG_8;
                4'd9:    o_seg = SEG_9;
                default: o_seg = SEG_BLANK;
            endcase
        end
    end

endmodule

// File: rtl/result_bcd_display.sv
// Sequential binary-to-BCD (one bit per clock) driving three HEX digits plus a sign digit.
// Build option SIGNED_DISPLAY_EN: treat value as two's complement and show a minus sign.
module result_bcd_display
    import result_bcd_display_pkg::*;
#(
    parameter int WIDTH = 7
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [WIDTH-1:0] value,
    input  logic             borrow,
    output logic             busy,
    output logic             done,
    output logic [11:0]      bcd,
    output logic [6:0]       hex0,
    output logic [6:0]       hex1,
    output logic [6:0]       hex2,
    output logic [6:0]       hex3,
    output logic             flag_led
);

    localparam int CNT_W = $clog2(WIDTH + 1);

    state_t           r_state;
    state_t           w_state_next;
    logic [WIDTH-1:0] r_shift;
    logic [11:0]      r_scratch;
    logic [CNT_W-1:0] r_cnt;
    logic             r_borrow;
    logic             r_neg;
    logic [11:0]      r_bcd;
    logic             r_sign;
    logic             r_flag;
    logic             r_done;

    logic [WIDTH-1:0] w_mag;
    logic             w_neg;
    logic [11:0]      w_adj;
    logic [11:0]      w_scratch_next;
    logic             w_last;

`ifdef SIGNED_DISPLAY_EN
    // Negation at capture keeps latency identical; the most negative value maps onto itself.
    assign w_neg = value[WIDTH-1];
    assign w_mag = w_neg ? (~value) + {{(WIDTH-1){1'b0}}, 1'b1} : value;
`else
    assign w_neg = 1'b0;
    assign w_mag = value;
`endif

    assign w_adj          = {add3(r_scratch[11:8]), add3(r_scratch[7:4]), add3(r_scratch[3:0])};
    assign w_scratch_next = 12'({w_adj, r_shift[WIDTH-1]});
    assign w_last         = (r_cnt == CNT_W'(1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= ST_IDLE;
        else        r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: if (load)   w_state_next = ST_CONV;
            ST_CONV: if (w_last) w_state_next = ST_IDLE;
            default:             w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_shift   <= '0;
            r_scratch <= '0;
            r_cnt     <= '0;
            r_borrow  <= 1'b0;
            r_neg     <= 1'b0;
            r_bcd     <= '0;
            r_sign    <= 1'b0;
            r_flag    <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (load) begin
                        r_shift   <= w_mag;
                        r_scratch <= '0;
                        r_cnt     <= CNT_W'(WIDTH);
                        r_borrow  <= borrow;
                        r_neg     <= w_neg;
                    end
                end
                ST_CONV: begin
                    r_scratch <= w_scratch_next;
                    r_shift   <= r_shift << 1;
                    r_cnt     <= r_cnt - CNT_W'(1);
                    // Visible outputs change only here, so partial digits never show.
                    if (w_last) begin
                        r_bcd  <= w_scratch_next;
                        r_sign <= r_neg;
                        r_flag <= r_borrow;
                        r_done <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy     = (r_state == ST_CONV);
    assign done     = r_done;
    assign bcd      = r_bcd;
    assign flag_led = r_flag;
    assign hex3     = r_sign ? SEG_MINUS : SEG_BLANK;

    seg7_digit u_dig0 (.i_digit(r_bcd[3:0]),  .i_blank(1'b0),                  .o_seg(hex0));
    seg7_digit u_dig1 (.i_digit(r_bcd[7:4]),  .i_blank(r_bcd[11:4] == 8'd0),   .o_seg(hex1));
    seg7_digit u_dig2 (.i_digit(r_bcd[11:8]), .i_blank(r_bcd[11:8] == 4'd0),   .o_seg(hex2));

endmodule
